// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: FSM state, register address width and the
// enable/flush encodings driven into the PC and pipeline buffers.
package hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    MULTI = 1'b1
  } state_e;

  // One set of register enables and bubble loads for the front pipeline.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                      ex_mem_en: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0};
  localparam pipe_ctrl_t CTRL_HOLD = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0,
                                       ex_mem_en: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b0};
  localparam pipe_ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                         ex_mem_en: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1};
  localparam pipe_ctrl_t CTRL_BUBBLE = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1,
                                         ex_mem_en: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b1};
  localparam pipe_ctrl_t CTRL_RESET = '{pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0,
                                        ex_mem_en: 1'b0, if_id_flush: 1'b1, id_ex_flush: 1'b1};

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: decode/execute hazard inputs in, pipeline enables,
// flushes, multi-cycle phase and stall counter out.
//   master: pipeline side (drives hazard inputs, receives controls)
//   slave : hazard_ctrl
interface hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = hazard_ctrl_pkg::REG_ADDR_W,
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned PERF_W     = 16
);
  logic [REG_ADDR_W-1:0] id_rsrc1;
  logic [REG_ADDR_W-1:0] id_rsrc2;
  logic                  id_use_src1;
  logic                  id_use_src2;
  logic [REG_ADDR_W-1:0] ex_rdst;
  logic                  ex_mem_read;
  logic                  ex_reg_write;
  logic                  ex_branch_taken;
  logic                  mem_multi_start;
  logic                  perf_clr;
  logic                  pc_en;
  logic                  if_id_en;
  logic                  id_ex_en;
  logic                  ex_mem_en;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic [CNT_W-1:0]      mem_phase;
  logic [PERF_W-1:0]     stall_cnt;

  modport master (
    output id_rsrc1, id_rsrc2, id_use_src1, id_use_src2, ex_rdst, ex_mem_read,
           ex_reg_write, ex_branch_taken, mem_multi_start, perf_clr,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
           mem_phase, stall_cnt
  );

  modport slave (
    input  id_rsrc1, id_rsrc2, id_use_src1, id_use_src2, ex_rdst, ex_mem_read,
           ex_reg_write, ex_branch_taken, mem_multi_start, perf_clr,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
           mem_phase, stall_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
//   clk, rst_n : clock, async active-low reset
//   inc, clr   : count enable, synchronous clear
//   cnt        : current count, sticks at all-ones
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubble, taken-branch flush and
// front-end freeze during multi-cycle MEM ops, plus a stall counter.
//   clk : rising-edge clock
//   rst : async active-low reset (holds pipeline empty while low)
//   hz  : hazard_ctrl_if slave (hazard inputs, enables/flushes, phase, count)
module hazard_ctrl #(
  parameter int unsigned REG_ADDR_W   = hazard_ctrl_pkg::REG_ADDR_W,
  parameter int unsigned MULTI_CYCLES = 2,
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned PERF_W       = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);
  import hazard_ctrl_pkg::*;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  phase_q, phase_d;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic              load_use;
  logic              freeze;
  logic              stall_inc;
  pipe_ctrl_t        ctrl;
  logic [PERF_W-1:0] perf_cnt;

  assign rs1 = hz.id_rsrc1;
  assign rs2 = hz.id_rsrc2;
  assign rd  = hz.ex_rdst;

  assign load_use = hz.ex_mem_read & hz.ex_reg_write &
                    ((hz.id_use_src1 & (rs1 == rd)) | (hz.id_use_src2 & (rs2 == rd)));

  // Freeze covers the start cycle and every MULTI cycle except the release.
  assign freeze = ((state_q == IDLE) & hz.mem_multi_start) |
                  ((state_q == MULTI) & (cnt_q != '0));

  // State, remaining-access counter and phase index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Multi-cycle op sequencing; start is ignored in the release cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        if (hz.mem_multi_start) begin
          state_d = MULTI;
          cnt_d   = CNT_W'(MULTI_CYCLES - 2);
          phase_d = CNT_W'(1);
        end
      end
      MULTI: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - CNT_W'(1);
          phase_d = phase_q + CNT_W'(1);
        end else begin
          state_d = IDLE;
          phase_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        phase_d = '0;
      end
    endcase
  end

  // Control priority: reset > freeze > branch > load-use.
  always_comb begin
    ctrl = CTRL_RUN;
    if (!rst) begin
      ctrl = CTRL_RESET;
    end else if (freeze) begin
      ctrl = CTRL_HOLD;
    end else if (hz.ex_branch_taken) begin
      ctrl = CTRL_BRANCH;
    end else if (load_use) begin
      ctrl = CTRL_BUBBLE;
    end
  end

  // A branch swallows the load-use bubble, so it is not counted as a stall.
  assign stall_inc = freeze | (load_use & ~hz.ex_branch_taken);

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (stall_inc),
    .clr   (hz.perf_clr),
    .cnt   (perf_cnt)
  );

  assign hz.pc_en       = ctrl.pc_en;
  assign hz.if_id_en    = ctrl.if_id_en;
  assign hz.id_ex_en    = ctrl.id_ex_en;
  assign hz.ex_mem_en   = ctrl.ex_mem_en;
  assign hz.if_id_flush = ctrl.if_id_flush;
  assign hz.id_ex_flush = ctrl.id_ex_flush;
  assign hz.mem_phase   = phase_q;
  assign hz.stall_cnt   = perf_cnt;

endmodule
